esn7e_demo_system_ram_stream_reader: RTL and testbench
======================================================

// Module: esn7e_demo_system_ram_stream_reader
// PURPOSE
//  Avalon-MM read master that fetches a block of 32-bit words from the on-chip
//  instruction/data RAM slave and presents them on an Avalon-ST source.
//  Started by a control pulse carrying base word address and length; it issues
//  pipelined reads, buffers returned data in a small FIFO, and pulses done
//  when the last word has been accepted downstream. Sits between the Nios II
//  RAM and the ESN datapath/stream consumers.
// PARAMETERS
//  ADDR_W      16     word-address width (matches RAM slave address port)
//  DATA_W      32     data word width
//  LEN_W       16     transfer-length width, in words
//  FIFO_DEPTH  8      return-data FIFO entries; power of 2, >= 2
// PORTS
//  clk            in   1        single clock
//  reset_n        in   1        asynchronous, active-low reset
//  start          in   1        1-cycle pulse; latched only when busy==0
//  base_addr      in   ADDR_W   first word address, sampled with start
//  length         in   LEN_W    number of words, sampled with start
//  busy           out  1        high from accepted start until done
//  done           out  1        1-cycle pulse at end of transfer
//  m_address      out  ADDR_W   Avalon-MM word address
//  m_read         out  1        Avalon-MM read request
//  m_waitrequest  in   1        slave stall; request held while high
//  m_readdata     in   DATA_W   read data
//  m_readdatavalid in  1        read data valid (pipelined reads)
//  st_data        out  DATA_W   stream data
//  st_valid       out  1        stream valid
//  st_ready       in   1        stream backpressure
// BEHAVIOUR
//  - Reset (reset_n low, any time, async): busy=0, done=0, m_read=0,
//    m_address=0, st_valid=0, FIFO emptied, counters=0, state=IDLE. Reset
//    mid-transfer abandons it; in-flight readdatavalid after release ignored.
//  - FSM: IDLE -> (start, length!=0) ISSUE -> (all reads accepted) DRAIN ->
//    (last word taken by st) IDLE with done=1 for one cycle.
//    start with length==0: no reads, busy stays 0, done pulses next cycle.
//    start while busy=1: ignored.
//  - Read accepted when m_read & ~m_waitrequest. While stalled, m_read and
//    m_address held stable. After each acceptance m_address increments by 1,
//    modulo 2^ADDR_W (wrap, no error).
//  - Credit rule: issue a read only if outstanding + fifo_count < FIFO_DEPTH;
//    FIFO therefore never overflows; readdatavalid always written.
//  - outstanding: +1 on acceptance, -1 on readdatavalid, both same cycle = 0.
//  - Min latency: read accepted cycle N, RAM data valid N+1, st_valid N+2.
//  - Back-to-back: one read per cycle sustained when st_ready=1, no stall.
//  - st_valid = FIFO not empty; word popped on st_valid & st_ready; st_data
//    stable while st_valid & ~st_ready. Simultaneous push/pop on full or
//    empty FIFO legal; count unchanged.
//  - done asserted the cycle after the final pop; busy drops same cycle.
//  - Words emitted in address order; exactly `length` words per transfer.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/ISSUE/DRAIN), default widths.
//  - Sub-module: esn7e_demo_system_ram_stream_fifo (sync FIFO, DATA_W x
//    FIFO_DEPTH, show-ahead, count output, async active-low reset).
//  - Top: FSM, address/remaining/outstanding counters, credit logic.
// TESTING
//  - base=0x0010,len=4, RAM=addr-pattern, ready=1 -> st words 0x10..0x13,
//    reads on 4 consecutive cycles, done 1 cycle after last pop.
//  - waitrequest high 3 cycles on 2nd read -> m_address/m_read held, output
//    order/count unchanged.
//  - st_ready=0 throughout, len=20 -> exactly 8 reads issued, then stall;
//    release ready -> remaining 12 issued, 20 words out, no loss.
//  - base=0xFFFE,len=4 -> addresses FFFE,FFFF,0000,0001; len=0 -> no
//    m_read, done pulse, busy never high.
//  - reset_n low mid-transfer with 3 reads outstanding -> all outputs reset
//    immediately; new start after release yields correct, clean stream.
//  - start pulsed while busy -> ignored; transfer count/addresses unaffected.

Source files
------------

// File: rtl/esn7e_demo_system_ram_stream_reader_pkg.sv
//==============================================================================
// Module : esn7e_demo_system_ram_stream_reader_pkg
// Brief  : Shared widths and FSM encoding for the RAM stream reader.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package esn7e_demo_system_ram_stream_reader_pkg;

    localparam int c_addr_w     = 16;
    localparam int c_data_w     = 32;
    localparam int c_len_w      = 16;
    localparam int c_fifo_depth = 8;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

endpackage

`default_nettype wire

// File: rtl/esn7e_demo_system_ram_stream_fifo.sv
//==============================================================================
// Module : esn7e_demo_system_ram_stream_fifo
// Brief  : Show-ahead synchronous FIFO with occupancy count.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module esn7e_demo_system_ram_stream_fifo
    import esn7e_demo_system_ram_stream_reader_pkg::*;
#(
    parameter int DATA_W     = c_data_w,
    parameter int FIFO_DEPTH = c_fifo_depth
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_push_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_pop_data,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is fine when the same cycle frees a slot.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/esn7e_demo_system_ram_stream_reader.sv
//==============================================================================
// Module : esn7e_demo_system_ram_stream_reader
// Brief  : Avalon-MM pipelined read master streaming a RAM block to Avalon-ST.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module esn7e_demo_system_ram_stream_reader
    import esn7e_demo_system_ram_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w,
    parameter int DATA_W     = c_data_w,
    parameter int LEN_W      = c_len_w,
    parameter int FIFO_DEPTH = c_fifo_depth
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_done;
    logic              w_done_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_issue_left;
    logic [LEN_W-1:0]  r_words_left;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W:0]    w_inflight;
    logic              w_credit;
    logic              w_accept;
    logic              w_rdv;
    logic              w_pop;
    logic              w_fifo_empty;

    // Words in flight plus words buffered can never exceed the FIFO, so
    // every returned word always has a slot.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_credit   = (w_inflight < (CNT_W+1)'(FIFO_DEPTH));

    assign m_read    = (r_state == c_st_issue) & w_credit;
    assign m_address = r_addr;
    assign w_accept  = m_read & ~m_waitrequest;
    // Returns with nothing outstanding are leftovers of an aborted transfer.
    assign w_rdv     = m_readdatavalid & (r_outstanding != '0);
    assign st_valid  = ~w_fifo_empty;
    assign w_pop     = st_valid & st_ready;
    assign busy      = (r_state != c_st_idle);
    assign done      = r_done;

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    if (length != '0) begin
                        w_state_next = c_st_issue;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            c_st_issue: begin
                if (w_accept && (r_issue_left == LEN_W'(1))) begin
                    w_state_next = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_pop && (r_words_left == LEN_W'(1))) begin
                    w_state_next = c_st_idle;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_issue_left  <= '0;
            r_words_left  <= '0;
            r_outstanding <= '0;
        end else begin
            if (r_state == c_st_idle) begin
                if (start && (length != '0)) begin
                    r_addr       <= base_addr;
                    r_issue_left <= length;
                    r_words_left <= length;
                end
            end else begin
                if (w_accept) begin
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_issue_left <= r_issue_left - LEN_W'(1);
                end
                if (w_pop) begin
                    r_words_left <= r_words_left - LEN_W'(1);
                end
            end
            case ({w_accept, w_rdv})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    esn7e_demo_system_ram_stream_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_rdv),
        .i_push_data (m_readdata),
        .i_pop       (w_pop),
        .o_pop_data  (st_data),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_esn7e_demo_system_ram_stream_reader.sv
//==============================================================================
// Module : tb_esn7e_demo_system_ram_stream_reader
// Brief  : Scoreboard bench with an Avalon-MM RAM model for the stream reader.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_esn7e_demo_system_ram_stream_reader;

    typedef struct packed {
        int          due;
        logic [15:0] addr;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] length = '0;
    logic        busy;
    logic        done;
    logic [15:0] m_address;
    logic        m_read;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = 32'hDEADBEEF;
    logic        m_readdatavalid = 1'b0;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;

    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    ret_t        ret_q[$];

    int   n_acc = 0;
    int   first_acc_cycle = 0;
    int   last_acc_cycle = 0;
    int   done_cnt = 0;
    int   done_cycle = 0;
    logic done_busy = 1'b0;
    int   last_pop_cycle = 0;
    int   stall_idx = -1;
    int   stall_left = 0;
    logic stall_seen = 1'b0;
    logic [15:0] stall_addr = '0;
    int   ram_lat = 1;

    esn7e_demo_system_ram_stream_reader dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .busy            (busy),
        .done            (done),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .st_ready        (st_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {16'h0000, a};
    endfunction

    // RAM slave: accepts requests on the falling edge, returns after ram_lat cycles.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall_seen && m_waitrequest) begin
                check("stall_read_hold", {31'd0, m_read}, 32'd1);
            end
            if (m_read === 1'b1 && m_waitrequest) begin
                if (stall_seen) begin
                    check("stall_addr_hold", {16'd0, m_address}, {16'd0, stall_addr});
                end
                stall_seen = 1'b1;
                stall_addr = m_address;
                stall_left--;
            end else if (m_read === 1'b1) begin
                if (exp_addr.size() == 0) begin
                    check("extra_read", 32'd1, 32'd0);
                end else begin
                    check("read_addr", {16'd0, m_address}, {16'd0, exp_addr.pop_front()});
                end
                ret_q.push_back('{due: cycle + ram_lat, addr: m_address});
                n_acc++;
                if (n_acc == 1) first_acc_cycle = cycle;
                last_acc_cycle = cycle;
                stall_seen = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        ret_t r;
        #1;
        m_readdatavalid = 1'b0;
        m_readdata      = 32'hDEADBEEF;
        if (ret_q.size() != 0 && ret_q[0].due <= cycle) begin
            r = ret_q.pop_front();
            m_readdatavalid = 1'b1;
            m_readdata      = ram_word(r.addr);
        end
        m_waitrequest = (stall_left > 0) && (n_acc == stall_idx);
        if (!m_waitrequest) stall_seen = 1'b0;
    end

    // Stream monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (st_valid && st_ready) begin
                if (exp_data.size() == 0) begin
                    check("extra_word", 32'd1, 32'd0);
                end else begin
                    check("st_data", st_data, exp_data.pop_front());
                end
                last_pop_cycle = cycle;
            end
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
                done_busy  = busy;
            end
        end
    end

    task automatic push_exp(input logic [15:0] b, input int l);
        logic [15:0] a;
        for (int i = 0; i < l; i++) begin
            a = b + 16'(i);
            exp_addr.push_back(a);
            exp_data.push_back(ram_word(a));
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int prev;
        int k;
        prev = done_cnt;
        k = 0;
        while (done_cnt == prev && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == prev) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_after_last_pop", 32'(done_cycle - last_pop_cycle), 32'd1);
            check("busy_low_at_done", {31'd0, done_busy}, 32'd0);
            check("all_words_out", 32'(exp_data.size()), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_m_read", {31'd0, m_read}, 32'd0);
        check("rst_m_address", {16'd0, m_address}, 32'd0);
        check("rst_st_valid", {31'd0, st_valid}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic block, back-to-back reads
        n_acc = 0;
        push_exp(16'h0010, 4);
        do_start(16'h0010, 16'd4);
        wait_done(50);
        check("t1_reads", 32'(n_acc), 32'd4);
        check("t1_consecutive", 32'(last_acc_cycle - first_acc_cycle), 32'd3);

        // Waitrequest on the second read for three cycles
        n_acc = 0;
        stall_idx = 1;
        stall_left = 3;
        push_exp(16'h0100, 4);
        do_start(16'h0100, 16'd4);
        wait_done(50);
        check("t2_reads", 32'(n_acc), 32'd4);
        check("t2_stall_consumed", 32'(stall_left), 32'd0);
        check("t2_stall_span", 32'(last_acc_cycle - first_acc_cycle), 32'd6);
        stall_idx = -1;

        // Backpressure: credit limits issue to the FIFO depth
        st_ready = 1'b0;
        n_acc = 0;
        push_exp(16'h0200, 20);
        do_start(16'h0200, 16'd20);
        repeat (40) @(posedge clk);
        #1;
        check("t3_reads_credit", 32'(n_acc), 32'd8);
        check("t3_busy", {31'd0, busy}, 32'd1);
        check("t3_st_valid", {31'd0, st_valid}, 32'd1);
        check("t3_no_read", {31'd0, m_read}, 32'd0);
        st_ready = 1'b1;
        wait_done(100);
        check("t3_reads", 32'(n_acc), 32'd20);

        // Address wrap
        n_acc = 0;
        push_exp(16'hFFFE, 4);
        do_start(16'hFFFE, 16'd4);
        wait_done(50);
        check("t4_reads", 32'(n_acc), 32'd4);

        // Zero length
        n_acc = 0;
        base_addr = 16'h0050;
        length    = 16'd0;
        start     = 1'b1;
        @(negedge clk);
        check("len0_busy_a", {31'd0, busy}, 32'd0);
        check("len0_done_a", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_done_pulse", {31'd0, done}, 32'd1);
        check("len0_busy_b", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("len0_done_end", {31'd0, done}, 32'd0);
        check("len0_busy_c", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_reads", 32'(n_acc), 32'd0);

        // Start while busy is ignored
        n_acc = 0;
        push_exp(16'h0300, 6);
        do_start(16'h0300, 16'd6);
        @(posedge clk); #1;
        do_start(16'h0400, 16'd3);
        wait_done(50);
        check("t6_reads", 32'(n_acc), 32'd6);
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_restart", {31'd0, busy}, 32'd0);
        check("t6_reads_after", 32'(n_acc), 32'd6);

        // Asynchronous reset with three reads outstanding
        ram_lat = 4;
        n_acc = 0;
        push_exp(16'h0500, 10);
        do_start(16'h0500, 16'd10);
        k = 0;
        while (n_acc < 3 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("t7_three_accepted", 32'(n_acc), 32'd3);
        check("t7_returns_pending", 32'(ret_q.size()), 32'd3);
        reset_n = 1'b0;
        #1;
        check("t7_rst_busy", {31'd0, busy}, 32'd0);
        check("t7_rst_m_read", {31'd0, m_read}, 32'd0);
        check("t7_rst_m_address", {16'd0, m_address}, 32'd0);
        check("t7_rst_st_valid", {31'd0, st_valid}, 32'd0);
        check("t7_rst_done", {31'd0, done}, 32'd0);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t7_stale_drained", 32'(ret_q.size()), 32'd0);
        check("t7_stale_ignored", {31'd0, st_valid}, 32'd0);
        check("t7_idle", {31'd0, busy}, 32'd0);
        ram_lat = 1;
        n_acc = 0;
        push_exp(16'h0600, 5);
        do_start(16'h0600, 16'd5);
        wait_done(50);
        check("t7_reads_after_reset", 32'(n_acc), 32'd5);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
